// File: rtl/jtcop_arb_pkg.sv
// Shared types and constants for the SDRAM bank arbiter.
//   state_e      : arbiter FSM states
//   cmd_t        : latched command payload driven onto the SDRAM command port
//   PROG_SRC     : source index used for the download (prog) port
//   bank_onehot  : 2-bit bank index to 4-bit one-hot strobe vector
package jtcop_arb_pkg;

    localparam int unsigned AW = 22;
    localparam int unsigned DW = 16;
    localparam int unsigned NB = 4;
    localparam int unsigned BW = 2;
    localparam int unsigned SW = 3;

    // Sources 0..3 are the banks; 4 is the download port.
    localparam logic [SW-1:0] PROG_SRC = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RDATA = 2'd2,
        WDATA = 2'd3
    } state_e;

    typedef struct packed {
        logic [BW-1:0] ba;
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] din;
        logic [1:0]    mask;
    } cmd_t;

    function automatic logic [NB-1:0] bank_onehot(input logic [BW-1:0] idx);
        return NB'(1) << idx;
    endfunction

endpackage

// File: rtl/jtcop_rr_pick.sv
// Combinational 4-way round-robin finder: first set request at or above ptr, with wrap.
//   req_i      : request vector
//   ptr_i      : highest-priority index
//   onehot_c_o : one-hot of the chosen request
//   idx_c_o    : index of the chosen request
//   any_c_o    : at least one request is set
module jtcop_rr_pick
    import jtcop_arb_pkg::*;
(
    input  logic [NB-1:0] req_i,
    input  logic [BW-1:0] ptr_i,
    output logic [NB-1:0] onehot_c_o,
    output logic [BW-1:0] idx_c_o,
    output logic          any_c_o
);

    // Walk from ptr upward; index arithmetic wraps naturally at BW bits.
    always_comb begin
        logic [BW-1:0] cand;
        onehot_c_o = '0;
        idx_c_o    = '0;
        any_c_o    = 1'b0;
        cand       = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            cand = ptr_i + BW'(i);
            if (!any_c_o && req_i[cand]) begin
                any_c_o    = 1'b1;
                idx_c_o    = cand;
                onehot_c_o = NB'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/jtcop_bank_arb.sv
// Serialises four bank request ports plus the download port onto a single-outstanding
// SDRAM command port, and returns per-bank ack/dst/dok/rdy strobes with registered read data.
//   ba*_addr, ba_rd, ba_wr, ba0_din(_m) : bank requests (held until ack)
//   ba_ack/ba_dst/ba_dok/ba_rdy, data_read : bank responses
//   downloading, prog_*                 : download port, exclusive while downloading
//   cmd_*, cmd_gnt                      : SDRAM command handshake
//   rd_valid/rd_data, wr_done           : SDRAM completion
//   tout_err                            : sticky response timeout flag
module jtcop_bank_arb
    import jtcop_arb_pkg::*;
#(
    parameter int unsigned BURST = 2,
    parameter int unsigned TOUT  = 63
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ba0_addr,
    input  logic [AW-1:0] ba1_addr,
    input  logic [AW-1:0] ba2_addr,
    input  logic [AW-1:0] ba3_addr,
    input  logic [NB-1:0] ba_rd,
    input  logic          ba_wr,
    input  logic [DW-1:0] ba0_din,
    input  logic [1:0]    ba0_din_m,
    output logic [NB-1:0] ba_ack,
    output logic [NB-1:0] ba_dst,
    output logic [NB-1:0] ba_dok,
    output logic [NB-1:0] ba_rdy,
    output logic [DW-1:0] data_read,
    input  logic          downloading,
    input  logic [AW-1:0] prog_addr,
    input  logic [DW-1:0] prog_data,
    input  logic [1:0]    prog_mask,
    input  logic [BW-1:0] prog_ba,
    input  logic          prog_we,
    input  logic          prog_rd,
    output logic          prog_ack,
    output logic          prog_rdy,
    output logic          cmd_req,
    output logic [BW-1:0] cmd_ba,
    output logic [AW-1:0] cmd_addr,
    output logic          cmd_wr,
    output logic [DW-1:0] cmd_din,
    output logic [1:0]    cmd_mask,
    input  logic          cmd_gnt,
    input  logic          rd_valid,
    input  logic [DW-1:0] rd_data,
    input  logic          wr_done,
    output logic          tout_err
);

    // Timeout counter holds 0..TOUT-1; reaching TOUT-1 in a wait state aborts.
    localparam int unsigned   TW    = (TOUT < 2) ? 1 : $clog2(TOUT);
    localparam logic [TW-1:0] TLAST = TW'(TOUT - 1);
    localparam logic          WLAST = 1'(BURST - 1);

    state_e        state_q, state_d;
    cmd_t          cmd_q, cmd_d;
    logic          cmd_req_q, cmd_req_d;
    logic [SW-1:0] src_q, src_d;
    logic [BW-1:0] rr_ptr_q, rr_ptr_d;
    logic          wcnt_q, wcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tout_err_q, tout_err_d;
    logic [DW-1:0] data_q, data_d;
    logic [NB-1:0] ack_q, ack_d;
    logic [NB-1:0] dst_q, dst_d;
    logic [NB-1:0] dok_q, dok_d;
    logic [NB-1:0] rdy_q, rdy_d;
    logic          pack_q, pack_d;
    logic          prdy_q, prdy_d;

    logic [NB-1:0] bank_req;
    logic [NB-1:0] pick_oh;
    logic [BW-1:0] pick_idx;
    logic          pick_any;
    logic [AW-1:0] pick_addr;
    logic          is_prog;
    logic [NB-1:0] src_oh;

    // Bank 0 carries both read and write requests.
    assign bank_req = {ba_rd[3:1], ba_rd[0] | ba_wr};

    jtcop_rr_pick u_pick (
        .req_i      (bank_req),
        .ptr_i      (rr_ptr_q),
        .onehot_c_o (pick_oh),
        .idx_c_o    (pick_idx),
        .any_c_o    (pick_any)
    );

    assign pick_addr = ({AW{pick_oh[0]}} & ba0_addr) | ({AW{pick_oh[1]}} & ba1_addr)
                     | ({AW{pick_oh[2]}} & ba2_addr) | ({AW{pick_oh[3]}} & ba3_addr);

    assign is_prog = (src_q == PROG_SRC);
    assign src_oh  = bank_onehot(src_q[BW-1:0]);

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        cmd_req_d  = cmd_req_q;
        src_d      = src_q;
        rr_ptr_d   = rr_ptr_q;
        wcnt_d     = wcnt_q;
        tcnt_d     = tcnt_q;
        tout_err_d = tout_err_q;
        data_d     = data_q;
        ack_d      = '0;
        dst_d      = '0;
        dok_d      = '0;
        rdy_d      = '0;
        pack_d     = 1'b0;
        prdy_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (downloading) begin
                    if (prog_we || prog_rd) begin
                        cmd_d     = '{ba: prog_ba, addr: prog_addr, wr: prog_we,
                                      din: prog_data, mask: prog_mask};
                        src_d     = PROG_SRC;
                        cmd_req_d = 1'b1;
                        state_d   = ISSUE;
                    end
                end else if (pick_any) begin
                    // A simultaneous bank 0 read and write resolves to the write.
                    cmd_d     = '{ba: pick_idx, addr: pick_addr, wr: pick_oh[0] & ba_wr,
                                  din: ba0_din, mask: ba0_din_m};
                    src_d     = SW'({1'b0, pick_idx});
                    cmd_req_d = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_gnt) begin
                    cmd_req_d = 1'b0;
                    wcnt_d    = 1'b0;
                    tcnt_d    = '0;
                    if (is_prog) begin
                        pack_d = 1'b1;
                    end else begin
                        ack_d    = src_oh;
                        rr_ptr_d = src_q[BW-1:0] + 2'd1;
                    end
                    state_d = cmd_q.wr ? WDATA : RDATA;
                end
            end
            RDATA: begin
                tcnt_d = tcnt_q + 1'b1;
                if (rd_valid) begin
                    data_d = rd_data;
                    if (!is_prog) begin
                        dok_d = src_oh;
                        if (wcnt_q == 1'b0) dst_d = src_oh;
                    end
                    if (wcnt_q == WLAST) begin
                        if (is_prog) prdy_d = 1'b1;
                        else         rdy_d  = src_oh;
                        state_d = IDLE;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end else if (tcnt_q == TLAST) begin
                    tout_err_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            WDATA: begin
                tcnt_d = tcnt_q + 1'b1;
                if (wr_done) begin
                    if (is_prog) prdy_d = 1'b1;
                    else         rdy_d  = src_oh;
                    state_d = IDLE;
                end else if (tcnt_q == TLAST) begin
                    tout_err_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            cmd_req_q  <= 1'b0;
            src_q      <= '0;
            rr_ptr_q   <= '0;
            wcnt_q     <= 1'b0;
            tcnt_q     <= '0;
            tout_err_q <= 1'b0;
            data_q     <= '0;
            ack_q      <= '0;
            dst_q      <= '0;
            dok_q      <= '0;
            rdy_q      <= '0;
            pack_q     <= 1'b0;
            prdy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            cmd_req_q  <= cmd_req_d;
            src_q      <= src_d;
            rr_ptr_q   <= rr_ptr_d;
            wcnt_q     <= wcnt_d;
            tcnt_q     <= tcnt_d;
            tout_err_q <= tout_err_d;
            data_q     <= data_d;
            ack_q      <= ack_d;
            dst_q      <= dst_d;
            dok_q      <= dok_d;
            rdy_q      <= rdy_d;
            pack_q     <= pack_d;
            prdy_q     <= prdy_d;
        end
    end

    assign ba_ack    = ack_q;
    assign ba_dst    = dst_q;
    assign ba_dok    = dok_q;
    assign ba_rdy    = rdy_q;
    assign data_read = data_q;
    assign prog_ack  = pack_q;
    assign prog_rdy  = prdy_q;
    assign cmd_req   = cmd_req_q;
    assign cmd_ba    = cmd_q.ba;
    assign cmd_addr  = cmd_q.addr;
    assign cmd_wr    = cmd_q.wr;
    assign cmd_din   = cmd_q.din;
    assign cmd_mask  = cmd_q.mask;
    assign tout_err  = tout_err_q;

endmodule
